// File: rtl/nn_pkg.sv
// Shared definitions for the nn_* classifier blocks: FSM state codes,
// default layer geometry and the signed-minimum seed for second-best tracking.
package nn_pkg;

  localparam int NN_N_CLASSES = 10;
  localparam int NN_DATA_W    = 16;
  localparam int NN_IDX_W     = 4;

  // Argmax FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Most negative activation at the default width; seeds second-best
  localparam logic signed [NN_DATA_W-1:0] NN_SMIN = {1'b1, {(NN_DATA_W-1){1'b0}}};

endpackage

// File: rtl/nn_argmax_cell.sv
// Single-element argmax update: folds activation x (at index cnt) into the
// running best/index, and, with NN_ARGMAX_MARGIN_EN, the running second best.
// Strict signed compare so a tie keeps the earlier (lower) index.
module nn_argmax_cell #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4
) (
  input  logic signed [DATA_W-1:0] best,
`ifdef NN_ARGMAX_MARGIN_EN
  input  logic signed [DATA_W-1:0] second,
  output logic signed [DATA_W-1:0] second_nxt,
`endif
  input  logic        [IDX_W-1:0]  idx,
  input  logic signed [DATA_W-1:0] x,
  input  logic        [IDX_W-1:0]  cnt,
  output logic signed [DATA_W-1:0] best_nxt,
  output logic        [IDX_W-1:0]  idx_nxt
);

  // Compare x against the current best (and second best) and pick the winners
  always_comb begin
    best_nxt = best;
    idx_nxt  = idx;
`ifdef NN_ARGMAX_MARGIN_EN
    second_nxt = second;
`endif
    if (x > best) begin
      best_nxt = x;
      idx_nxt  = cnt;
`ifdef NN_ARGMAX_MARGIN_EN
      second_nxt = best;
`endif
    end else begin
      best_nxt = best;
      idx_nxt  = idx;
`ifdef NN_ARGMAX_MARGIN_EN
      if (x > second) begin
        second_nxt = x;
      end else begin
        second_nxt = second;
      end
`endif
    end
  end

endmodule

// File: rtl/nn_argmax.sv
// Classifier output stage: captures the dense-layer activation vector on a
// level-high done, scans one element per cycle for the maximum and presents
// class index and value over valid/ready. Optional feature macro:
// NN_ARGMAX_MARGIN_EN adds out_margin = best - second best (DATA_W+1 bits).
module nn_argmax
  import nn_pkg::*;
#(
  parameter int N_CLASSES = NN_N_CLASSES,
  parameter int DATA_W    = NN_DATA_W,
  parameter int IDX_W     = NN_IDX_W
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          in_valid,
  input  logic [N_CLASSES*DATA_W-1:0]   in_vec,
  output logic                          in_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [IDX_W-1:0]              out_class,
  output logic signed [DATA_W-1:0]      out_max,
`ifdef NN_ARGMAX_MARGIN_EN
  output logic signed [DATA_W:0]        out_margin,
`endif
  output logic                          busy
);

  localparam logic signed [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic [1:0]                      state_r, state_nxt_s;
  logic                            armed_r, armed_nxt_s;
  logic                            in_ready_r, busy_r, out_valid_r;
  logic [N_CLASSES*DATA_W-1:0]     buf_r;
  logic signed [DATA_W-1:0]        best_r, best_nxt_s;
  logic [IDX_W-1:0]                idx_r, idx_nxt_s, cnt_r;
  logic [IDX_W-1:0]                out_class_r;
  logic signed [DATA_W-1:0]        out_max_r;
  logic [DATA_W-1:0]               x_s;
  logic                            accept_s, last_s;
`ifdef NN_ARGMAX_MARGIN_EN
  logic signed [DATA_W-1:0]        second_r, second_nxt_s;
  logic signed [DATA_W:0]          out_margin_r;
`endif

  assign accept_s = (state_r == ST_IDLE) && armed_r && in_valid;
  assign last_s   = (cnt_r == IDX_W'(N_CLASSES-1));

  // Select buffered element cnt_r as an AND-OR mux (out-of-range cnt gives 0)
  always_comb begin
    x_s = {DATA_W{1'b0}};
    for (int k = 0; k < N_CLASSES; k++) begin
      x_s = x_s | (buf_r[k*DATA_W +: DATA_W] & {DATA_W{cnt_r == IDX_W'(k)}});
    end
  end

  nn_argmax_cell #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_cell (
    .best       (best_r),
`ifdef NN_ARGMAX_MARGIN_EN
    .second     (second_r),
    .second_nxt (second_nxt_s),
`endif
    .idx        (idx_r),
    .x          (x_s),
    .cnt        (cnt_r),
    .best_nxt   (best_nxt_s),
    .idx_nxt    (idx_nxt_s)
  );

  // Next-state and re-arm logic; a sampled low done re-arms the block
  always_comb begin
    state_nxt_s = state_r;
    armed_nxt_s = armed_r;
    if (!in_valid) begin
      armed_nxt_s = 1'b1;
    end else if (accept_s) begin
      armed_nxt_s = 1'b0;
    end else begin
      armed_nxt_s = armed_r;
    end
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = ST_SCAN;
        else          state_nxt_s = ST_IDLE;
      end
      ST_SCAN: begin
        if (last_s) state_nxt_s = ST_HOLD;
        else        state_nxt_s = ST_SCAN;
      end
      ST_HOLD: begin
        if (out_valid_r && out_ready) state_nxt_s = ST_IDLE;
        else                          state_nxt_s = ST_HOLD;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Control registers; in_ready/busy are registered from next-state values
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= ST_IDLE;
      armed_r    <= 1'b1;
      in_ready_r <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      armed_r    <= armed_nxt_s;
      in_ready_r <= (state_nxt_s == ST_IDLE) && armed_nxt_s;
      busy_r     <= (state_nxt_s != ST_IDLE);
    end
  end

  // Datapath: capture on accept, fold one element per SCAN cycle, publish on last
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buf_r        <= {(N_CLASSES*DATA_W){1'b0}};
      best_r       <= {DATA_W{1'b0}};
      idx_r        <= {IDX_W{1'b0}};
      cnt_r        <= {IDX_W{1'b0}};
      out_valid_r  <= 1'b0;
      out_class_r  <= {IDX_W{1'b0}};
      out_max_r    <= {DATA_W{1'b0}};
`ifdef NN_ARGMAX_MARGIN_EN
      second_r     <= {DATA_W{1'b0}};
      out_margin_r <= {(DATA_W+1){1'b0}};
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            buf_r  <= in_vec;
            best_r <= in_vec[DATA_W-1:0];
            idx_r  <= {IDX_W{1'b0}};
            cnt_r  <= IDX_W'(1);
`ifdef NN_ARGMAX_MARGIN_EN
            second_r <= SMIN;
`endif
          end
        end
        ST_SCAN: begin
          best_r <= best_nxt_s;
          idx_r  <= idx_nxt_s;
          cnt_r  <= cnt_r + IDX_W'(1);
`ifdef NN_ARGMAX_MARGIN_EN
          second_r <= second_nxt_s;
`endif
          if (last_s) begin
            out_valid_r <= 1'b1;
            out_class_r <= idx_nxt_s;
            out_max_r   <= best_nxt_s;
`ifdef NN_ARGMAX_MARGIN_EN
            out_margin_r <= {best_nxt_s[DATA_W-1], best_nxt_s}
                          - {second_nxt_s[DATA_W-1], second_nxt_s};
`endif
          end
        end
        ST_HOLD: begin
          if (out_ready) out_valid_r <= 1'b0;
        end
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

  assign in_ready   = in_ready_r;
  assign busy       = busy_r;
  assign out_valid  = out_valid_r;
  assign out_class  = out_class_r;
  assign out_max    = out_max_r;
`ifdef NN_ARGMAX_MARGIN_EN
  assign out_margin = out_margin_r;
`endif

endmodule

// File: tb/tb_nn_argmax.sv
// Directed self-checking bench for nn_argmax (default geometry 10 x 16-bit).
// Margin checks are active when NN_ARGMAX_MARGIN_EN is defined.
module tb_nn_argmax;

  localparam int N = 10;
  localparam int W = 16;
  localparam int I = 4;

  logic                 clk;
  logic                 rstn;
  logic                 in_valid;
  logic [N*W-1:0]       in_vec;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [I-1:0]         out_class;
  logic signed [W-1:0]  out_max;
  logic                 busy;
`ifdef NN_ARGMAX_MARGIN_EN
  logic signed [W:0]    out_margin;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int vals [N];

  nn_argmax #(.N_CLASSES(N), .DATA_W(W), .IDX_W(I)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_vec     (in_vec),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_class  (out_class),
    .out_max    (out_max),
`ifdef NN_ARGMAX_MARGIN_EN
    .out_margin (out_margin),
`endif
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*W-1:0] pack_vals();
    logic [N*W-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*W +: W] = vals[k][W-1:0];
    return v;
  endfunction

  // Steps until out_valid or a 30-cycle budget runs out; lat = -1 on timeout
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 30) begin
      step();
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic chk_margin(input string tag, input int exp_mrg);
`ifdef NN_ARGMAX_MARGIN_EN
    chk(tag, out_margin, exp_mrg);
`endif
  endtask

  // Single-pulse transaction on vals; checks latency and result, optionally releases
  task automatic run_vec(input string tag, input int exp_cls, input int exp_max,
                         input int exp_mrg, input bit rel);
    int lat;
    chk({tag, "_in_ready_pre"}, in_ready, 1);
    in_vec   = pack_vals();
    in_valid = 1'b1;
    step();                              // accept edge 0
    in_valid = 1'b0;
    in_vec   = '1;                       // must be ignored after capture
    chk({tag, "_in_ready_busy"}, in_ready, 0);
    chk({tag, "_busy"}, busy, 1);
    wait_valid(lat);
    chk({tag, "_latency"}, lat, 9);
    chk({tag, "_class"}, out_class, exp_cls);
    chk({tag, "_max"}, out_max, exp_max);
    chk_margin({tag, "_margin"}, exp_mrg);
    if (rel) begin
      step();
      chk({tag, "_valid_drop"}, out_valid, 0);
      chk({tag, "_busy_drop"}, busy, 0);
      chk({tag, "_class_kept"}, out_class, exp_cls);
    end
  endtask

  initial begin
    int seen;
    int lat;
    logic [I-1:0] cls_snap;
    logic signed [W-1:0] max_snap;

    rstn = 1'b0; in_valid = 1'b0; in_vec = '0; out_ready = 1'b1;
    step(); step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_class", out_class, 0);
    chk("rst_max", out_max, 0);
    chk_margin("rst_margin", 0);
    rstn = 1'b1;
    step();

    // Basic vector
    vals = '{3, 9, 1, 0, 0, 0, 0, 0, 0, 7};
    run_vec("basic", 1, 9, 2, 1'b1);
    chk("basic_in_ready_back", in_ready, 1);

    // All zeros
    vals = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_vec("zeros", 0, 0, 0, 1'b1);

    // Tie keeps lower index
    vals = '{10, 10, 50, 10, 10, 10, 50, 10, 10, 10};
    run_vec("tie", 2, 50, 0, 1'b1);

    // Signed negatives
    vals = '{-5, -5, -5, -5, -5, -5, -5, -5, -1, -5};
    run_vec("signed", 8, -1, 4, 1'b1);

    // Level-held done: exactly one result in 40 cycles
    vals = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 100};
    in_vec = pack_vals();
    in_valid = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (out_valid) seen++;
    end
    chk("level_one_result", seen, 1);
    chk("level_class", out_class, 9);
    chk("level_max", out_max, 100);
    chk_margin("level_margin", 100);
    chk("level_no_rearm", in_ready, 0);
    in_valid = 1'b0;
    step();
    chk("level_rearmed", in_ready, 1);
    vals = '{7, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    in_vec = pack_vals();
    in_valid = 1'b1;
    step();
    wait_valid(lat);
    chk("level2_latency", lat, 9);
    chk("level2_class", out_class, 0);
    chk("level2_max", out_max, 7);
    in_valid = 1'b0;
    step();

    // Reset at edge 4 of SCAN aborts with no result
    vals = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    in_vec = pack_vals();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) step();
    rstn = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_valid", out_valid, 0);
    chk("abort_class", out_class, 0);
    chk("abort_max", out_max, 0);
    step(); step();
    rstn = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (out_valid) seen++;
    end
    chk("abort_no_pulse", seen, 0);
    run_vec("post_rst", 9, 10, 1, 1'b1);

    // Backpressure: outputs stable and in_ready low for 20 cycles
    out_ready = 1'b0;
    vals = '{20, 5, 5, 5, 5, 5, 5, 5, 5, 5};
    run_vec("hold", 0, 20, 15, 1'b0);
    cls_snap = out_class;
    max_snap = out_max;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (!out_valid || in_ready || out_class !== cls_snap || out_max !== max_snap) seen++;
    end
    chk("hold_stable_cycles_bad", seen, 0);
    chk("hold_class", out_class, 0);
    chk("hold_max", out_max, 20);
    out_ready = 1'b1;
    step();
    chk("hold_release_valid", out_valid, 0);
    chk("hold_release_in_ready", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nn_argmax.md
# nn_argmax

Classifier output stage placed directly after the 10-neuron dense layer. It captures the layer's ReLU output vector when the layer signals completion, then scans one element per cycle to find the largest activation. It presents the winning class index and value to the consumer over a valid/ready handshake.

## Interface
- `N_CLASSES`, default 10: number of input activations, ≥2.
- `DATA_W`, default 16: activation width, signed two's complement.
- `IDX_W`, default 4: class index width, ≥ clog2(N_CLASSES).

- `clk` input, 1: single clock, rising edge.
- `rstn` input, 1: asynchronous active-low reset.
- `in_valid` input, 1: layer done, level-sensitive; stays high while results are held.
- `in_vec` input, N_CLASSES*DATA_W: activations; element k at [k*DATA_W +: DATA_W]. Element 0 is neuron 1.
- `in_ready` output, 1: block can accept a vector.
- `out_valid` output, 1: result available.
- `out_ready` input, 1: consumer accepts result.
- `out_class` output, IDX_W: index of the maximum element.
- `out_max` output, DATA_W signed: value of the maximum element.
- `busy` output, 1: state is not IDLE.
- `out_margin` output, DATA_W+1 signed: present only with `NN_ARGMAX_MARGIN_EN`.

## Operation
- FSM states:
  - IDLE:
    - `in_ready` = `armed`.
    - Accept when `in_valid && in_ready`. On accept:
      - latch `in_vec` into an internal buffer;
      - best = elem0, idx = 0, cnt = 1;
      - clear `armed`;
      - go to SCAN.
  - SCAN: each cycle compare buf[cnt] against best.
    - Compare is signed and strict (>). On a tie the lower index is kept.
    - cnt increments each cycle.
    - After processing cnt == N_CLASSES-1, go to HOLD and register `out_valid` = 1.
  - HOLD:
    - `out_class`, `out_max` (and `out_margin`) are stable.
    - On `out_valid && out_ready`, go to IDLE and clear `out_valid`.
    - Outputs keep their last values until the next result.
- Re-arm:
  - `armed` is set in any cycle where `in_valid` == 0 is sampled.
  - A level-high done that is still asserted on return to IDLE does not trigger a second accept.
- `in_vec` changes after accept are ignored; the buffer is used exclusively.
- `in_valid` asserted while in SCAN or HOLD is ignored, apart from its effect on `armed`.
- Reset values:
  - state IDLE, `armed` = 1, `in_ready` = 1;
  - `out_valid` = 0, `busy` = 0;
  - `out_class` = 0, `out_max` = 0, `out_margin` = 0;
  - buffer = 0.
- Reset mid-SCAN or mid-HOLD aborts immediately. No partial result is ever presented.

## Timing
- The accept edge is edge 0.
- `out_valid` rises after edge N_CLASSES-1. For the default N_CLASSES = 10 that is edge 9.
- `in_ready` is low from edge 0 until the state returns to IDLE with `armed` set.
- With `out_ready` held high:
  - HOLD lasts exactly 1 cycle;
  - earliest next accept is 1 cycle after return to IDLE, provided `in_valid` dropped and re-rose.
- `out_ready` high before `out_valid` has no effect.
- `out_valid` and the data outputs are driven directly from registers. There is no combinational path from `in_*` to `out_*`.

## Configuration
- `NN_ARGMAX_MARGIN_EN` defined:
  - also tracks the second-best value; `out_margin` = best − second, computed in DATA_W+1 bits.
  - second-best initialises to −2^(DATA_W−1) at accept.
  - Per element x:
    - if x > best: second ← best, best ← x;
    - else if x > second: second ← x.
  - A tie with best gives margin 0.
- Undefined:
  - no `out_margin` port and no second-best register.
  - Latency and all other behaviour are identical.

## Structure
- Shared package `nn_pkg`:
  - state enum (IDLE, SCAN, HOLD);
  - default N_CLASSES / DATA_W constants;
  - signed minimum constant used for second-best init.
- One sub-module `nn_argmax_cell`, combinational. It takes (best, second, idx, x, cnt) and returns the updated values. It is reused as the single per-cycle comparator.

## Test plan
- Vector [3,9,1,0,0,0,0,0,0,7], single `in_valid` pulse, `out_ready` = 1 → `out_valid` 9 cycles after accept; `out_class` = 1, `out_max` = 9; margin 2 when enabled.
- All zeros → `out_class` = 0, `out_max` = 0, margin 0.
- Tie: element 2 = element 6 = 50, rest 10 → `out_class` = 2, margin 0.
- Signed: all elements −5 except element 8 = −1 → `out_class` = 8, `out_max` = −1.
- `in_valid` held high for 40 cycles, `out_ready` = 1 → exactly one result. Drop `in_valid` for 1 cycle and raise it again → second result.
- Assert reset at edge 4 of SCAN → all outputs return to reset values, `out_valid` never pulses, next vector processes normally. Separately, hold `out_ready` = 0 for 20 cycles → outputs stable, `in_ready` = 0 throughout.
